// File: rtl/frame_align_fsm.sv
// ISERDES frame aligner: issues bitslip pulses until the registered parallel word
// equals the frame pattern, then holds lock with match/mismatch hysteresis.
module frame_align_fsm #(
    parameter int         DATA_WIDTH    = 8,
    parameter logic [7:0] FRAME_PATTERN = 8'b00001111,
    parameter int         SLIP_WAIT     = 4,
    parameter int         LOCK_COUNT    = 16,
    parameter int         UNLOCK_COUNT  = 4
) (
    input  logic                  clk_div,
    input  logic                  reset,
    input  logic                  ena,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  bitslip,
    output logic                  locked,
    output logic                  lock_lost,
    output logic                  align_fail,
    output logic [3:0]            slip_count,
    output logic [3:0]            offset
);
    localparam logic [DATA_WIDTH-1:0] PATTERN     = FRAME_PATTERN[DATA_WIDTH-1:0];
    localparam logic [4:0]            ATTEMPT_MAX = 5'(2 * DATA_WIDTH);
    localparam logic [7:0]            LOCK_MAX    = 8'(LOCK_COUNT);
    localparam logic [7:0]            UNLOCK_MAX  = 8'(UNLOCK_COUNT);
    localparam logic [3:0]            WAIT_LAST   = 4'(SLIP_WAIT - 1);
    localparam logic [3:0]            SLIP_LAST   = 4'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, CHECK, SLIP, WAIT, LOCKED} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] data_q;
    logic [7:0]            good_cnt, good_nxt, bad_cnt, bad_nxt;
    logic [7:0]            good_inc, bad_inc;
    logic [4:0]            attempts, attempts_nxt, attempts_inc;
    logic [3:0]            wait_cnt, wait_nxt;
    logic                  bitslip_nxt, locked_nxt, lock_lost_nxt, align_fail_nxt;
    logic [3:0]            slip_count_nxt, offset_nxt;
    logic                  match;

    function automatic logic [DATA_WIDTH-1:0] rotl(input logic [DATA_WIDTH-1:0] v, input int k);
        logic [2*DATA_WIDTH-1:0] dbl;
        dbl = {v, v} << k;
        return dbl[2*DATA_WIDTH-1 -: DATA_WIDTH];
    endfunction

    assign match        = (data_q == PATTERN);
    assign good_inc     = (good_cnt == 8'hFF) ? good_cnt : good_cnt + 8'd1;
    assign bad_inc      = (bad_cnt == 8'hFF) ? bad_cnt : bad_cnt + 8'd1;
    assign attempts_inc = (attempts == ATTEMPT_MAX) ? attempts : attempts + 5'd1;

    always_comb begin
        // NOTE: every *_nxt is given a default first so no branch can infer a latch.
        state_nxt      = state;
        good_nxt       = good_cnt;
        bad_nxt        = bad_cnt;
        attempts_nxt   = attempts;
        wait_nxt       = wait_cnt;
        slip_count_nxt = slip_count;
        offset_nxt     = offset;
        locked_nxt     = locked;
        align_fail_nxt = align_fail;
        bitslip_nxt    = 1'b0;
        lock_lost_nxt  = 1'b0;

        if (!ena) begin
            state_nxt      = IDLE;
            locked_nxt     = 1'b0;
            align_fail_nxt = 1'b0;
        end else begin
            // Descending scan so the lowest matching rotation wins.
            offset_nxt = 4'hF;
            for (int k = DATA_WIDTH - 1; k >= 0; k--) begin
                if (data_q == rotl(PATTERN, k)) offset_nxt = 4'(k);
            end

            unique case (state)
                IDLE: begin
                    state_nxt    = CHECK;
                    good_nxt     = 8'd0;
                    bad_nxt      = 8'd0;
                    attempts_nxt = 5'd0;
                end
                CHECK: begin
                    if (match) begin
                        good_nxt = good_inc;
                        if (good_inc == LOCK_MAX) begin
                            state_nxt    = LOCKED;
                            locked_nxt   = 1'b1;
                            attempts_nxt = 5'd0;
                        end
                    end else begin
                        good_nxt       = 8'd0;
                        state_nxt      = SLIP;
                        bitslip_nxt    = 1'b1;
                        slip_count_nxt = (slip_count == SLIP_LAST) ? 4'd0 : slip_count + 4'd1;
                        attempts_nxt   = attempts_inc;
                        if (attempts_inc == ATTEMPT_MAX) align_fail_nxt = 1'b1;
                    end
                end
                SLIP: begin
                    state_nxt = WAIT;
                    wait_nxt  = 4'd0;
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) state_nxt = CHECK;
                    else                       wait_nxt  = wait_cnt + 4'd1;
                end
                LOCKED: begin
                    if (match) begin
                        bad_nxt = 8'd0;
                    end else begin
                        bad_nxt = bad_inc;
                        if (bad_inc == UNLOCK_MAX) begin
                            state_nxt     = CHECK;
                            locked_nxt    = 1'b0;
                            lock_lost_nxt = 1'b1;
                            good_nxt      = 8'd0;
                            bad_nxt       = 8'd0;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_div or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            data_q     <= '0;
            good_cnt   <= 8'd0;
            bad_cnt    <= 8'd0;
            attempts   <= 5'd0;
            wait_cnt   <= 4'd0;
            bitslip    <= 1'b0;
            locked     <= 1'b0;
            lock_lost  <= 1'b0;
            align_fail <= 1'b0;
            slip_count <= 4'd0;
            offset     <= 4'hF;
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values.
            state      <= state_nxt;
            data_q     <= data_in;
            good_cnt   <= good_nxt;
            bad_cnt    <= bad_nxt;
            attempts   <= attempts_nxt;
            wait_cnt   <= wait_nxt;
            bitslip    <= bitslip_nxt;
            locked     <= locked_nxt;
            lock_lost  <= lock_lost_nxt;
            align_fail <= align_fail_nxt;
            slip_count <= slip_count_nxt;
            offset     <= offset_nxt;
        end
    end
endmodule

// File: tb/tb_frame_align_fsm.sv
// Scoreboard bench: a rotating-word ISERDES model feeds the aligner; expected
// bitslip/lock/lock_lost events are queued from the alignment rules and a monitor pops them.
module tb_frame_align_fsm;
    localparam int LC = 16;

    typedef enum int {EV_SLIP, EV_LOCK, EV_LOST} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
        int       off;
        int       sc;
        int       af;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena8, ena4;
    logic [7:0] data8;
    logic [3:0] data4;
    logic       bs8, lk8, ll8, af8, bs4, lk4, ll4, af4;
    logic [3:0] sc8, of8, sc4, of4;

    bit   sel, ena_m, ovr_en, mon_en;
    int   ovr_val, rot, cur_dw, cur_pat, cur_wait;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    bit   locked_d = 1'b0;
    ev_t  q[$];

    logic       m_bitslip, m_locked, m_lock_lost, m_align_fail;
    logic [3:0] m_slip_count, m_offset;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    frame_align_fsm #(.DATA_WIDTH(8), .FRAME_PATTERN(8'b00001111), .SLIP_WAIT(4),
                      .LOCK_COUNT(16), .UNLOCK_COUNT(4)) u_dut8 (
        .clk_div(clk), .reset(rst), .ena(ena8), .data_in(data8), .bitslip(bs8),
        .locked(lk8), .lock_lost(ll8), .align_fail(af8), .slip_count(sc8), .offset(of8));

    frame_align_fsm #(.DATA_WIDTH(4), .FRAME_PATTERN(8'b00000011), .SLIP_WAIT(2),
                      .LOCK_COUNT(16), .UNLOCK_COUNT(4)) u_dut4 (
        .clk_div(clk), .reset(rst), .ena(ena4), .data_in(data4), .bitslip(bs4),
        .locked(lk4), .lock_lost(ll4), .align_fail(af4), .slip_count(sc4), .offset(of4));

    assign m_bitslip    = sel ? bs4 : bs8;
    assign m_locked     = sel ? lk4 : lk8;
    assign m_lock_lost  = sel ? ll4 : ll8;
    assign m_align_fail = sel ? af4 : af8;
    assign m_slip_count = sel ? sc4 : sc8;
    assign m_offset     = sel ? of4 : of8;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rotl_w(input int v, input int k, input int w);
        int r = v;
        for (int i = 0; i < k; i++) r = ((r << 1) | (r >> (w - 1))) & ((1 << w) - 1);
        return r;
    endfunction

    function automatic bit is_rot(input int v);
        for (int k = 0; k < cur_dw; k++) if (rotl_w(cur_pat, k, cur_dw) == v) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int bad_word();
        int v;
        do v = int'($urandom_range(0, (1 << cur_dw) - 1)); while (is_rot(v));
        return v;
    endfunction

    task automatic apply();
        int word;
        word  = ovr_en ? ovr_val : rotl_w(cur_pat, rot, cur_dw);
        data8 = sel ? 8'h00 : 8'(word);
        data4 = sel ? 4'(word) : 4'h0;
        ena8  = ena_m && !sel;
        ena4  = ena_m && sel;
    endtask

    // One frame-clock step of the ISERDES model: a sampled bitslip rotates the word by one.
    task automatic tick();
        @(negedge clk);
        if (m_bitslip) rot = (rot + 1) % cur_dw;
        apply();
    endtask

    task automatic push(input ev_kind_t kind, input int c, input int off, input int sc, input int af);
        ev_t e;
        e.kind = kind; e.cyc = c; e.off = off; e.sc = sc; e.af = af;
        q.push_back(e);
    endtask

    // ce: cycle CHECK is entered; n slips needed; r0: rotation seen at the first slip.
    task automatic expect_hunt(input int ce, input int n, input int r0, input int first_off, input int sc0);
        int p = cur_wait + 2;
        for (int i = 0; i < n; i++)
            push(EV_SLIP, ce + 1 + i * p, (i == 0 && first_off >= 0) ? first_off : (r0 + i) % cur_dw, -1, -1);
        if (n == 0) push(EV_LOCK, ce + LC, 0, sc0, -1);
        else        push(EV_LOCK, ce + 1 + (n - 1) * p + 1 + cur_wait + LC, 0, (sc0 + n) % cur_dw, -1);
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_timeout: %0d events outstanding, expected 0", tag, q.size());
            q.delete();
        end
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_bitslip"}, int'(m_bitslip), 0);
        check({tag, "_locked"}, int'(m_locked), 0);
        check({tag, "_lock_lost"}, int'(m_lock_lost), 0);
        check({tag, "_align_fail"}, int'(m_align_fail), 0);
        check({tag, "_slip_count"}, int'(m_slip_count), 0);
        check({tag, "_offset"}, int'(m_offset), 15);
    endtask

    task automatic observe(input ev_kind_t kind);
        ev_t e;
        if (q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_event: got %s at cyc %0d, expected none", kind.name(), cyc);
        end else begin
            e = q.pop_front();
            check("event_kind", int'(kind), int'(e.kind));
            check("event_cyc", cyc, e.cyc);
            if (e.off >= 0) check("event_offset", int'(m_offset), e.off);
            if (e.sc >= 0)  check("event_slip_count", int'(m_slip_count), e.sc);
            if (e.af >= 0)  check("event_align_fail", int'(m_align_fail), e.af);
            if (kind == EV_LOST) check("lost_drops_locked", int'(m_locked), 0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (m_bitslip) observe(EV_SLIP);
            if (m_locked && !locked_d) observe(EV_LOCK);
            if (m_lock_lost) observe(EV_LOST);
        end
        locked_d = m_locked;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, cn, r, n, sc_model, w;
        int words[9];

        rst = 1'b0; sel = 1'b0; ena_m = 1'b0; ovr_en = 1'b0; ovr_val = 0; rot = 0;
        cur_dw = 8; cur_pat = 8'h0F; cur_wait = 4; mon_en = 1'b0;
        apply();
        #1 rst = 1'b1;
        tick(); tick();
        chk_reset("por");
        check("por4_offset", int'(of4), 15);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (10) tick();
        check("idle_no_lock", int'(m_locked), 0);

        // Aligned stream: lock with no slips.
        t0 = cyc; ena_m = 1'b1; apply();
        expect_hunt(t0 + 1, 0, 0, -1, 0);
        drain(400, "aligned");

        // 3 bad, 1 good, 4 bad, then one more bad so re-hunting starts with a slip.
        for (int j = 0; j < 9; j++) words[j] = (j == 3) ? cur_pat : bad_word();
        cn = cyc;
        push(EV_LOST, cn + 9, -1, -1, -1);
        expect_hunt(cn + 9, 8, 0, 15, 0);
        ovr_en = 1'b1;
        for (int j = 0; j < 9; j++) begin
            ovr_val = words[j];
            apply();
            tick();
        end
        ovr_en = 1'b0; apply();
        drain(400, "relock");
        ena_m = 1'b0; apply();
        repeat (2) tick();
        check("ena_off_locked", int'(m_locked), 0);

        // Rotation 3 from reset: five slips then lock.
        rst = 1'b1; apply(); tick();
        chk_reset("rst_a");
        rst = 1'b0;
        rot = 3; apply(); repeat (3) tick();
        t0 = cyc; ena_m = 1'b1; apply();
        expect_hunt(t0 + 1, 5, 3, -1, 0);
        drain(400, "rot3");
        sc_model = 5;

        // Random misalignments; slip_count must persist across ena=0.
        for (int k = 0; k < 3; k++) begin
            ena_m = 1'b0; apply(); repeat (3) tick();
            check("retain_slip_count", int'(m_slip_count), sc_model);
            r = int'($urandom_range(1, 7));
            rot = r; apply(); repeat (3) tick();
            n = (8 - r) % 8;
            t0 = cyc; ena_m = 1'b1; apply();
            expect_hunt(t0 + 1, n, r, -1, sc_model);
            drain(400, "rand_rot");
            sc_model = (sc_model + n) % 8;
        end

        // Asynchronous reset during a bitslip pulse and during lock.
        mon_en = 1'b0;
        ena_m = 1'b0; apply(); repeat (3) tick();
        rot = 2; apply(); repeat (3) tick();
        ena_m = 1'b1; apply();
        w = 0;
        while (!m_bitslip && w < 50) begin tick(); w++; end
        check("saw_bitslip", int'(m_bitslip), 1);
        rst = 1'b1;
        #1 chk_reset("rst_slip");
        ena_m = 1'b0; apply(); tick();
        rst = 1'b0;
        rot = 0; apply(); repeat (3) tick();
        ena_m = 1'b1; apply();
        w = 0;
        while (!m_locked && w < 100) begin tick(); w++; end
        check("saw_locked", int'(m_locked), 1);
        rst = 1'b1;
        #1 chk_reset("rst_lock");
        ena_m = 1'b0; apply(); tick();
        rst = 1'b0;
        q.delete();
        tick();
        mon_en = 1'b1;

        // Unmatchable word: align_fail on the 16th slip, hunting continues.
        ovr_en = 1'b1; ovr_val = 8'hAA; apply(); repeat (3) tick();
        t0 = cyc; ena_m = 1'b1; apply();
        for (int i = 0; i < 18; i++)
            push(EV_SLIP, t0 + 2 + i * 6, 15, -1, (i < 15) ? 0 : ((i == 15) ? -1 : 1));
        drain(300, "align_fail");
        ena_m = 1'b0; apply(); repeat (3) tick();
        check("af_cleared_by_ena", int'(m_align_fail), 0);
        check("af_slip_count_kept", int'(m_slip_count), 18 % 8);
        ovr_en = 1'b0;

        // 4-bit instance: two hunts so slip_count wraps 3 -> 0.
        sel = 1'b1; cur_dw = 4; cur_pat = 3; cur_wait = 2;
        rst = 1'b1; apply(); tick();
        chk_reset("rst_w4");
        rst = 1'b0;
        rot = 1; apply(); repeat (3) tick();
        t0 = cyc; ena_m = 1'b1; apply();
        expect_hunt(t0 + 1, 3, 1, -1, 0);
        drain(400, "w4_first");
        ena_m = 1'b0; apply(); repeat (3) tick();
        check("w4_slip_count", int'(m_slip_count), 3);
        rot = 3; apply(); repeat (3) tick();
        t0 = cyc; ena_m = 1'b1; apply();
        expect_hunt(t0 + 1, 1, 3, -1, 3);
        drain(400, "w4_wrap");
        check("w4_wrapped", int'(m_slip_count), 0);
        check("w4_locked", int'(m_locked), 1);

        ena_m = 1'b0; apply(); repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/frame_align_fsm.md
FRAME_ALIGN_FSM -- requirements
Module: frame_align_fsm

Interface
REQ-001 Parameter DATA_WIDTH, default 8, ISERDES parallel width; legal values 4 or 8.
REQ-002 Parameter FRAME_PATTERN, default 8'b00001111, aligned frame word; only the low DATA_WIDTH bits are used.
REQ-003 Parameter SLIP_WAIT, default 4, idle cycles after each bitslip pulse; legal range 2..15.
REQ-004 Parameter LOCK_COUNT, default 16, consecutive matches required to declare lock; legal range 1..255.
REQ-005 Parameter UNLOCK_COUNT, default 4, consecutive mismatches while locked that drop lock; legal range 1..255.
REQ-006 clk_div  in  1  divided ISERDES clock; the only clock.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 ena  in  1  alignment enable.
REQ-009 data_in  in  DATA_WIDTH  parallel frame-clock word from the ISERDES.
REQ-010 bitslip  out  1  one-cycle bitslip request to the ISERDES.
REQ-011 locked  out  1  frame alignment achieved.
REQ-012 lock_lost  out  1  one-cycle pulse when lock is dropped.
REQ-013 align_fail  out  1  sticky; 2*DATA_WIDTH consecutive slips without lock.
REQ-014 slip_count  out  4  number of slips applied, modulo DATA_WIDTH.
REQ-015 offset  out  4  rotation of the current word relative to FRAME_PATTERN; 4'hF means no match.

Function
REQ-016 data_in SHALL be registered into data_q on every clk_div edge, regardless of ena; all decisions SHALL use data_q.
REQ-017 offset SHALL be registered each cycle while ena=1 as the lowest k in 0..DATA_WIDTH-1 with data_q == FRAME_PATTERN rotated left by k; otherwise 4'hF.
REQ-018 FSM states SHALL be IDLE, CHECK, SLIP, WAIT and LOCKED; all outputs SHALL be registered.
REQ-019 IDLE: when ena=1, go to CHECK with good_cnt, bad_cnt and attempts cleared; otherwise stay in IDLE.
REQ-020 CHECK: on a match, good_cnt increments; when the match brings good_cnt to LOCK_COUNT, go to LOCKED and set locked=1 on the same edge.
REQ-021 CHECK: on a mismatch, clear good_cnt and go to SLIP.
REQ-022 SLIP: bitslip=1 for exactly this one cycle; slip_count <= (slip_count+1) mod DATA_WIDTH; attempts increments; then go to WAIT.
REQ-023 WAIT: hold for SLIP_WAIT cycles with bitslip=0, then go to CHECK; bitslip pulses are therefore at least SLIP_WAIT+2 cycles apart.
REQ-024 align_fail SHALL set when attempts reaches 2*DATA_WIDTH; hunting continues; align_fail clears only on reset or when ena=0.
REQ-025 attempts SHALL clear on entry to LOCKED and saturate at 2*DATA_WIDTH.
REQ-026 LOCKED: a match clears bad_cnt; a mismatch increments bad_cnt.
REQ-027 LOCKED: when a mismatch brings bad_cnt to UNLOCK_COUNT, go to CHECK with locked=0, lock_lost=1 for one cycle, and good_cnt and bad_cnt cleared.
REQ-028 ena=0 in any state: next state IDLE, with locked, bitslip, lock_lost and align_fail set to 0 next cycle.
REQ-029 slip_count SHALL be retained across ena=0, because ISERDES slips persist.
REQ-030 ena=0 arriving during SLIP SHALL NOT extend or repeat the bitslip pulse.
REQ-031 Counter widths SHALL hold their maximum values without wrap; good_cnt and bad_cnt saturate.

Reset
REQ-032 reset=1 SHALL force state IDLE, data_q=0, bitslip=0, locked=0, lock_lost=0, align_fail=0, slip_count=0, offset=4'hF, and clear all internal counters, asynchronously.
REQ-033 reset asserted mid-SLIP SHALL drop bitslip immediately.
REQ-034 After reset deasserts, the FSM SHALL remain in IDLE until ena is sampled high.

Verification
REQ-035 Default parameters, data_in=8'h0F constant, ena raised -> locked=1 after the 16th edge following ena first sampled high; bitslip never pulses; offset=0.
REQ-036 data_in is a rotation of 8'h0F by 3, and the model rotates by 1 on each bitslip -> exactly 5 bitslip pulses spaced 6 cycles apart, then lock; slip_count=5.
REQ-037 Locked, then inject 3 bad words, 1 good word, then 4 bad words -> lock held through the first burst; lock_lost pulses once on the 4th consecutive bad word; the FSM resumes slipping.
REQ-038 data_in=8'hAA constant -> align_fail=1 after the 16th bitslip; offset=4'hF; hunting continues; ena=0 clears align_fail while slip_count is retained.
REQ-039 DATA_WIDTH=4, FRAME_PATTERN=4'b0011, SLIP_WAIT=2 -> slip_count wraps 3->0; lock is reached on the aligned rotation.
REQ-040 reset pulsed during a bitslip pulse and during LOCKED -> all outputs return to reset values in the same cycle.
